imem_fetch: RTL and testbench
=============================

# imem_fetch

Parametrised, synchronous instruction memory with a valid/ready fetch port, a separate program-load write port, and fault reporting. It replaces the fixed 32-entry combinational instruction ROM in the fetch stage. Requests carry XLEN-bit byte addresses. Responses return one registered cycle later, with instruction data and a fault code, and stall correctly under back-pressure from decode.

## Interface
- DEPTH, 32: number of ILEN-bit instruction words; power of two, at least 2.
- XLEN, 64: width of fetch and load addresses.
- ILEN, 32: instruction width; multiple of 8, power-of-two bytes.
- FILL_WORD, 32'hFFFF_FFFF: rsp_data value returned on any faulted fetch, ILEN bits wide.
- CNT_W, 32: width of fetch_count.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  block can accept a request this cycle.
- req_addr  in  XLEN  fetch byte address.
- rsp_valid  out  1  response held in the output register.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  ILEN  fetched instruction, or FILL_WORD on fault.
- rsp_fault  out  2  fault code: 00 ok, 01 misaligned, 10 out of range; 11 is never driven.
- ld_en  in  1  program-load write enable.
- ld_addr  in  XLEN  load byte address.
- ld_data  in  ILEN  load write data.
- fetch_count  out  CNT_W  number of accepted fetch requests.

## Operation
- BYTES = ILEN/8, OFS = log2(BYTES), word index = addr >> OFS.
- Misaligned: addr[OFS-1:0] != 0. Out of range: word index >= DEPTH, compared across the full XLEN width with no truncation before the compare.
- Fault priority: misaligned over out of range. A faulted fetch returns rsp_data = FILL_WORD and does not read the array.
- Output register has two states, EMPTY and FULL.
  - EMPTY -> FULL on accept.
  - FULL -> FULL on accept together with rsp_ready; the register reloads.
  - FULL -> EMPTY on rsp_ready with no accept.
- req_ready = !rsp_valid || rsp_ready, combinational from rsp_ready. No combinational path from req_* to rsp_*.
- Accept = req_valid && req_ready.
- Load path:
  - A load writes the array at the rising edge when ld_en is high, the load address is aligned, and it is in range.
  - A misaligned or out-of-range load is silently dropped.
  - Loads never stall and are independent of the fetch handshake.
- Collision: a fetch accepted in the same cycle as a valid load to the same word returns ld_data (write-first).
- fetch_count increments by 1 on every accept, faulted fetches included. It wraps from 2^CNT_W-1 to 0.
- Array contents are not cleared by rst_n. They power up as all-zero (simulation initial value) and are defined only after a load.

## Timing
- Reset values: rsp_valid=0, rsp_data=0, rsp_fault=00, fetch_count=0. req_ready=1 while in reset and on the first cycle after release.
- Reset asserted mid-operation drops any pending response immediately; no response is emitted for it. Loads presented during reset are ignored.
- Latency is one cycle: a request accepted at edge N gives rsp_valid=1 after edge N, and the data is valid in the same cycle.
- Throughput is one fetch per cycle while rsp_ready stays high.
- Stall: while rsp_valid && !rsp_ready, rsp_data and rsp_fault hold stable and req_ready=0.
- The response reflects array contents at the accept edge. A load to that word after acceptance does not alter the held response.

## Test plan
- Load words 0..3 with 0x11,0x22,0x33,0x44, then fetch byte addresses 0,4,8,12 back-to-back with rsp_ready=1 -> rsp_valid=1 on four consecutive cycles, data 0x11..0x44, fault 00, fetch_count=4.
- Fetch addr 0x6 -> rsp_fault=01, rsp_data=0xFFFFFFFF. Fetch addr 0x80 (word 32, DEPTH=32) -> fault 10. Fetch addr 0x1_0000_0000 -> fault 10, with no aliasing to word 0.
- Load word 1=0x22, fetch 4, hold rsp_ready=0 for 3 cycles -> req_ready=0 and rsp_data stays 0x22 for all 3 cycles. Then rsp_ready=1 with a new request to 8 -> the next response is word 2 with no bubble.
- Same cycle: ld_en to word 5 with 0xABCD and fetch 0x14 -> rsp_data=0xABCD. Load to misaligned 0x15 -> word 5 unchanged.
- Pulse rst_n low while rsp_valid=1 -> rsp_valid, rsp_data, rsp_fault and fetch_count go to 0 asynchronously. Array contents persist across the reset, so a fetch of 0x14 afterwards returns 0xABCD.
- With CNT_W=4, make 17 accepts -> fetch_count reads 1.

Source files
------------

// File: rtl/imem_fetch.sv
// Instruction memory with a registered valid/ready fetch port and a separate program-load port.
// Faulted fetches (misaligned or out of range) return FILL_WORD and never read the array.
module imem_fetch #(
    parameter int unsigned      DEPTH     = 32,
    parameter int unsigned      XLEN      = 64,
    parameter int unsigned      ILEN      = 32,
    parameter logic [ILEN-1:0]  FILL_WORD = ILEN'(32'hFFFF_FFFF),
    parameter int unsigned      CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [XLEN-1:0]  req_addr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ILEN-1:0]  rsp_data,
    output logic [1:0]       rsp_fault,
    input  logic             ld_en,
    input  logic [XLEN-1:0]  ld_addr,
    input  logic [ILEN-1:0]  ld_data,
    output logic [CNT_W-1:0] fetch_count
);

    localparam int unsigned BYTES = ILEN / 8;
    localparam int unsigned OFS   = $clog2(BYTES);
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(BYTES - 1);
    localparam logic [XLEN-1:0] DEPTH_X    = XLEN'(DEPTH);

    localparam logic [1:0] FAULT_OK  = 2'b00;
    localparam logic [1:0] FAULT_MIS = 2'b01;
    localparam logic [1:0] FAULT_OOR = 2'b10;

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    // Elaboration-time parameter sanity
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("imem_fetch: DEPTH must be a power of two >= 2");
    end
    if (ILEN % 8 != 0 || (BYTES & (BYTES - 1)) != 0) begin : g_bad_ilen
        $error("imem_fetch: ILEN must be a power-of-two number of bytes");
    end

    logic [ILEN-1:0] mem [DEPTH];

    logic [0:0]      state;
    logic [0:0]      state_nxt;
    logic            accept;
    logic [XLEN-1:0] req_widx;
    logic [XLEN-1:0] ld_widx;
    logic            req_mis;
    logic            req_oor;
    logic            ld_mis;
    logic            ld_oor;
    logic            ld_ok;
    logic            collide;
    logic [ILEN-1:0] data_nxt;
    logic [1:0]      fault_nxt;

    // Full-width word indices so high address bits can never alias into the array
    assign req_widx = req_addr >> OFS;
    assign ld_widx  = ld_addr >> OFS;

    assign req_mis = (req_addr & ALIGN_MASK) != '0;
    assign req_oor = req_widx >= DEPTH_X;
    assign ld_mis  = (ld_addr & ALIGN_MASK) != '0;
    assign ld_oor  = ld_widx >= DEPTH_X;

    // Loads are dropped while reset is asserted
    assign ld_ok   = rst_n && ld_en && !ld_mis && !ld_oor;
    assign collide = ld_ok && (ld_widx == req_widx);

    assign rsp_valid = (state == FULL);
    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;

    // Response payload for the request presented this cycle; write-first on a same-word load
    always_comb begin
        data_nxt  = FILL_WORD;
        fault_nxt = FAULT_OK;
        if (req_mis) begin
            fault_nxt = FAULT_MIS;
        end else if (req_oor) begin
            fault_nxt = FAULT_OOR;
        end else if (collide) begin
            data_nxt = ld_data;
        end else begin
            data_nxt = mem[req_widx[AW-1:0]];
        end
    end

    // Output register occupancy
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (!accept && rsp_ready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data    <= '0;
            rsp_fault   <= FAULT_OK;
            fetch_count <= '0;
        end else if (accept) begin
            rsp_data    <= data_nxt;
            rsp_fault   <= fault_nxt;
            fetch_count <= fetch_count + CNT_W'(1);
        end
    end

    // Array is not reset; contents survive rst_n
    always_ff @(posedge clk) begin
        if (ld_ok) begin
            mem[ld_widx[AW-1:0]] <= ld_data;
        end
    end

endmodule

// File: tb/tb_imem_fetch.sv
// Self-checking bench for imem_fetch: vector table plus hand-written stall, reset and wrap sequences.
module tb_imem_fetch;

    localparam logic [31:0] FILL = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_fault;
    logic        ld_en;
    logic [63:0] ld_addr;
    logic [31:0] ld_data;
    logic [3:0]  fetch_count;

    imem_fetch #(
        .DEPTH(32), .XLEN(64), .ILEN(32), .FILL_WORD(32'hFFFF_FFFF), .CNT_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_fault(rsp_fault),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        l_en;
        logic [63:0] l_addr;
        logic [31:0] l_data;
        logic        r_valid;
        logic [63:0] r_addr;
        logic [31:0] e_data;
        logic [1:0]  e_fault;
    } vec_t;

    vec_t        tbl [18];
    logic [33:0] sb_q [$];
    int          checks = 0;
    int          errors = 0;
    logic        model_valid = 1'b0;
    int          cnt_model = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: compare the held response when the consumer takes it
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else begin
                logic [33:0] e;
                e = sb_q.pop_front();
                chk("rsp_data", 64'(rsp_data), 64'(e[33:2]));
                chk("rsp_fault", 64'(rsp_fault), 64'(e[1:0]));
            end
        end
    end

    // One clock of stimulus; entered and left at posedge+1
    task automatic step(input logic l_en, input logic [63:0] l_addr, input logic [31:0] l_data,
                        input logic r_valid, input logic [63:0] r_addr, input logic r_ready,
                        input logic [31:0] e_data, input logic [1:0] e_fault);
        logic exp_rdy;
        logic acc;
        ld_en     = l_en;
        ld_addr   = l_addr;
        ld_data   = l_data;
        req_valid = r_valid;
        req_addr  = r_addr;
        rsp_ready = r_ready;
        #1;
        exp_rdy = !model_valid || r_ready;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        acc = r_valid && exp_rdy;
        @(posedge clk);
        if (acc) begin
            sb_q.push_back({e_data, e_fault});
            cnt_model++;
        end
        model_valid = acc ? 1'b1 : (r_ready ? 1'b0 : model_valid);
        #1;
        chk("rsp_valid", 64'(rsp_valid), 64'(model_valid));
        chk("fetch_count", 64'(fetch_count), 64'(cnt_model % 16));
    endtask

    task automatic idle(input logic r_ready);
        step(1'b0, 64'h0, 32'h0, 1'b0, 64'h0, r_ready, 32'h0, 2'b00);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 64'h0,           32'h11,        1'b0, 64'h0,           32'h0,        2'b00};
        tbl[1]  = '{1'b1, 64'h4,           32'h22,        1'b0, 64'h0,           32'h0,        2'b00};
        tbl[2]  = '{1'b1, 64'h8,           32'h33,        1'b0, 64'h0,           32'h0,        2'b00};
        tbl[3]  = '{1'b1, 64'hC,           32'h44,        1'b0, 64'h0,           32'h0,        2'b00};
        tbl[4]  = '{1'b0, 64'h0,           32'h0,         1'b1, 64'h0,           32'h11,       2'b00};
        tbl[5]  = '{1'b0, 64'h0,           32'h0,         1'b1, 64'h4,           32'h22,       2'b00};
        tbl[6]  = '{1'b0, 64'h0,           32'h0,         1'b1, 64'h8,           32'h33,       2'b00};
        tbl[7]  = '{1'b0, 64'h0,           32'h0,         1'b1, 64'hC,           32'h44,       2'b00};
        tbl[8]  = '{1'b0, 64'h0,           32'h0,         1'b1, 64'h6,           FILL,         2'b01};
        tbl[9]  = '{1'b0, 64'h0,           32'h0,         1'b1, 64'h80,          FILL,         2'b10};
        tbl[10] = '{1'b0, 64'h0,           32'h0,         1'b1, 64'h1_0000_0000, FILL,         2'b10};
        tbl[11] = '{1'b0, 64'h0,           32'h0,         1'b1, 64'h1_0000_0002, FILL,         2'b01};
        tbl[12] = '{1'b1, 64'h7C,          32'hCAFE_0031, 1'b1, 64'h7C,          32'hCAFE_0031, 2'b00};
        tbl[13] = '{1'b1, 64'h14,          32'hABCD,      1'b1, 64'h14,          32'hABCD,     2'b00};
        tbl[14] = '{1'b1, 64'h15,          32'h9999,      1'b1, 64'h14,          32'hABCD,     2'b00};
        tbl[15] = '{1'b1, 64'h80,          32'h5555,      1'b1, 64'h0,           32'h11,       2'b00};
        tbl[16] = '{1'b1, 64'h1_0000_0000, 32'h6666,      1'b1, 64'h0,           32'h11,       2'b00};
        tbl[17] = '{1'b0, 64'h0,           32'h0,         1'b1, 64'h0,           32'h11,       2'b00};

        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        #12;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_fault", 64'(rsp_fault), 64'd0);
        chk("rst_fetch_count", 64'(fetch_count), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].l_en, tbl[i].l_addr, tbl[i].l_data, tbl[i].r_valid, tbl[i].r_addr,
                 1'b1, tbl[i].e_data, tbl[i].e_fault);
        end
        idle(1'b1);

        // Back-pressure: response held for 3 cycles, a late load to the word does not disturb it
        step(1'b0, 64'h0, 32'h0, 1'b1, 64'h4, 1'b1, 32'h22, 2'b00);
        step(1'b1, 64'h4, 32'h77, 1'b1, 64'h8, 1'b0, 32'h33, 2'b00);
        chk("stall_data0", 64'(rsp_data), 64'h22);
        step(1'b0, 64'h0, 32'h0, 1'b1, 64'h8, 1'b0, 32'h33, 2'b00);
        chk("stall_data1", 64'(rsp_data), 64'h22);
        step(1'b0, 64'h0, 32'h0, 1'b1, 64'h8, 1'b0, 32'h33, 2'b00);
        chk("stall_data2", 64'(rsp_data), 64'h22);
        chk("stall_fault", 64'(rsp_fault), 64'h0);
        step(1'b0, 64'h0, 32'h0, 1'b1, 64'h8, 1'b1, 32'h33, 2'b00);
        chk("no_bubble_data", 64'(rsp_data), 64'h33);
        step(1'b0, 64'h0, 32'h0, 1'b1, 64'h4, 1'b1, 32'h77, 2'b00);
        idle(1'b1);

        // Asynchronous reset with a response pending; load during reset must be ignored
        step(1'b0, 64'h0, 32'h0, 1'b1, 64'h14, 1'b1, 32'hABCD, 2'b00);
        rsp_ready = 1'b0; req_valid = 1'b0;
        #2 rst_n = 1'b0;
        sb_q.delete();
        model_valid = 1'b0;
        cnt_model = 0;
        #1;
        chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("arst_rsp_data", 64'(rsp_data), 64'd0);
        chk("arst_rsp_fault", 64'(rsp_fault), 64'd0);
        chk("arst_fetch_count", 64'(fetch_count), 64'd0);
        chk("arst_req_ready", 64'(req_ready), 64'd1);
        ld_en = 1'b1; ld_addr = 64'h14; ld_data = 32'h1234;
        @(posedge clk); #1;
        ld_en = 1'b0;
        #2 rst_n = 1'b1;
        #1 chk("post_rst_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;

        // 17 accepts into a 4-bit counter, mixing ok and faulted fetches
        step(1'b0, 64'h0, 32'h0, 1'b1, 64'h14, 1'b1, 32'hABCD, 2'b00);
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) step(1'b0, 64'h0, 32'h0, 1'b1, 64'h6, 1'b1, FILL, 2'b01);
            else            step(1'b0, 64'h0, 32'h0, 1'b1, 64'hC, 1'b1, 32'h44, 2'b00);
        end
        idle(1'b1);
        chk("count_wrap", 64'(fetch_count), 64'd1);
        chk("sb_drain", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
